spi_pixel_frame_store: RTL and testbench
========================================

Name: spi_pixel_frame_store

Overview:
- Multi-channel, double-buffered pixel store between the SPI byte receiver (8-bit data + ready strobe) and NUM_CHANNELS WS2812-class string drivers.
- Each SSEL-framed SPI transaction carries one channel header byte, then pixel bytes.
- Pixels go into that channel's shadow bank. On SSEL release the frame is committed; it becomes visible to the driver only while the driver is in its reset/latch gap.
- Generalises the single-string bridge to N channels, 3- or 4-byte pixels (RGB/RGBW), explicit commit/pending handshake and error flags.

Parameters:
- NUM_CHANNELS, 4: number of independent LED strings.
- NUM_LEDS, 8: max pixels per channel per frame.
- BYTES_PER_LED, 3: 3 (GRB) or 4 (GRBW); any other value is an elaboration error.
- LED_AW, $clog2(NUM_LEDS): pixel address width (derived).
- CH_AW, max(1,$clog2(NUM_CHANNELS)): channel index width (derived).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- SSEL  in  1  raw SPI slave select, active-low, asynchronous to CLK.
- RX_DATA  in  8  received SPI byte.
- RX_READY  in  1  one-cycle strobe, RX_DATA valid.
- SWAP_REQ  in  NUM_CHANNELS  per-channel level from the driver, high during its reset/latch gap.
- RD_CH  in  CH_AW  read channel.
- RD_ADDR  in  LED_AW  read pixel index.
- RD_DATA  out  8*BYTES_PER_LED  pixel from the active bank; 1-cycle latency.
- RD_LIT  out  1  registered with RD_DATA: RD_ADDR < active count for RD_CH.
- PENDING  out  NUM_CHANNELS  committed frame awaiting swap.
- ACTIVE_BANK  out  NUM_CHANNELS  bank currently displayed per channel.
- ERR_BADCH  out  1  sticky: header byte >= NUM_CHANNELS.
- ERR_OVF  out  1  sticky: pixel bytes beyond NUM_LEDS pixels.
- ERR_PARTIAL  out  1  sticky: frame ended mid-pixel.

Behaviour:
- Reset: all outputs 0, all counts 0, state IDLE, SSEL synchroniser preset to 1. Storage contents need not be cleared; RD_LIT=0 forces RD_DATA=0.
- SSEL synchronisation:
  - 2-FF synchroniser plus a history bit.
  - start = sync 1->0; end = sync 0->1. Each detected one cycle after the second FF.
- FSM states: IDLE, HDR, PIX, DROP.
  - IDLE -> HDR on start: byte_idx=0, addr=0.
  - HDR, RX_READY:
    - byte < NUM_CHANNELS: cur_ch=byte, PENDING[cur_ch]<=0, shadow_cnt[cur_ch]<=0, go to PIX.
    - otherwise: ERR_BADCH<=1, go to DROP.
  - PIX, RX_READY:
    - Bytes fill pixel MSB-first: first byte -> [8*BPL-1 -: 8].
    - On byte BPL: write word to {cur_ch, ~ACTIVE_BANK[cur_ch], addr}, addr++, shadow_cnt++, byte_idx=0.
    - When addr==NUM_LEDS, further bytes are ignored and ERR_OVF<=1. No wrap.
  - DROP: ignore bytes until end.
  - end in HDR or DROP -> IDLE, no commit.
  - end in PIX -> IDLE:
    - If byte_idx!=0: partial pixel discarded, ERR_PARTIAL<=1.
    - PENDING[cur_ch]<=1 (even if 0 pixels: an empty frame blanks the string).
  - end and RX_READY in the same cycle: byte processed first, then end.
  - start seen outside IDLE (glitch) restarts HDR.
- Swap, per channel c, evaluated every cycle:
  - Condition: SWAP_REQ[c] && PENDING[c] && !(state==PIX && cur_ch==c).
  - Action: ACTIVE_BANK[c] flips, active_cnt[c]<=shadow_cnt[c], PENDING[c]<=0.
  - Multiple channels may swap in the same cycle.
  - Commit and SWAP_REQ in the same cycle: the swap happens the next cycle if SWAP_REQ is still high.
- New frame to a channel already PENDING: pending is cleared at the header, and the shadow bank is overwritten. No tearing, since the active bank is untouched.
- Read:
  - RD_DATA/RD_LIT registered from {RD_CH, ACTIVE_BANK[RD_CH], RD_ADDR}. The bank value is sampled the same cycle as the address.
  - RD_CH >= NUM_CHANNELS -> RD_LIT=0, RD_DATA=0.
- Storage:
  - Inferred simple dual-port RAM, depth 2^(CH_AW+1+LED_AW), width 8*BPL.
  - One write port (SPI side), one registered read port.
- Widths:
  - Counts are LED_AW+1 bits, saturating at NUM_LEDS.
  - addr comparison is done at LED_AW+1 bits.
- RST mid-frame: FSM to IDLE, all pending and active state cleared. The next start after RST release is treated normally.

Decomposition:
- Package spi_pix_pkg: FSM state enum (IDLE/HDR/PIX/DROP), pixel word width function, BYTES_PER_LED legality check constant.
- One sub-module, pix_sdp_ram: parametrised simple dual-port RAM with registered read.
- Synchroniser, FSM and swap logic stay in the top level.

Test Plan:
- NUM_CHANNELS=4, BPL=3.
  - Frame: hdr 0x01, bytes 11 22 33 44 55 66, release; SWAP_REQ[1] pulse.
  - Expect ACTIVE_BANK[1]=1 and PENDING[1]=0.
  - Reads ch1 addr0/1/2: 0x112233 LIT=1, 0x445566 LIT=1, 0x000000 LIT=0.
- Frame to ch2 while SWAP_REQ[2] held high throughout.
  - No swap until SSEL release.
  - Swap exactly 1 cycle after commit.
  - Ch2 old data still readable during the transfer.
- Header 0x07.
  - ERR_BADCH=1, following bytes ignored, no PENDING bit set.
- 9 pixels to NUM_LEDS=8 channel, then release.
  - ERR_OVF=1, active count 8 after swap.
  - Pixel 7 holds the 8th pixel, not the 9th.
- 7 data bytes.
  - 2 pixels stored, ERR_PARTIAL=1, count 2.
- BPL=4, NUM_CHANNELS=2 build.
  - Bytes AA BB CC DD -> RD_DATA 0xAABBCCDD.
  - RST asserted mid-frame -> all outputs 0; next frame accepted normally.

Source files
------------

// File: rtl/spi_pix_pkg.sv
// -----------------------------------------------------------------------------
// spi_pix_pkg
// Shared definitions for the SPI pixel frame store:
//   state_t    - receive FSM states (idle, header, pixel, drop)
//   pix_width  - pixel word width in bits for a given bytes-per-LED
//   bpl_legal  - legality check for the bytes-per-LED parameter (GRB/GRBW)
// -----------------------------------------------------------------------------
package spi_pix_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HDR,
      S_PIX,
      S_DROP
   } state_t;

   localparam int unsigned BPL_GRB  = 3;
   localparam int unsigned BPL_GRBW = 4;

   function automatic int unsigned pix_width(input int unsigned bpl);
      return 8 * bpl;
   endfunction

   function automatic bit bpl_legal(input int unsigned bpl);
      return (bpl == BPL_GRB) || (bpl == BPL_GRBW);
   endfunction

endpackage

// File: rtl/pix_sdp_ram.sv
// -----------------------------------------------------------------------------
// pix_sdp_ram
// Simple dual-port RAM: one write port, one read port with registered output.
// Contents are not reset.
// Ports:
//   i_clk            clock
//   i_we             write enable
//   i_waddr/i_wdata  write address / data
//   i_raddr          read address (sampled on i_clk)
//   o_rdata          read data, one cycle after i_raddr
// -----------------------------------------------------------------------------
module pix_sdp_ram #(
   parameter int unsigned AW = 6,
   parameter int unsigned DW = 24
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [2**AW];
   logic [DW-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_pixel_frame_store.sv
// -----------------------------------------------------------------------------
// spi_pixel_frame_store
// Multi-channel double-buffered pixel store between an SPI byte receiver and
// NUM_CHANNELS LED string drivers. Each SSEL-framed transaction carries a
// channel header byte followed by pixel bytes (MSB first). Pixels land in the
// channel's shadow bank; on SSEL release the frame is committed (PENDING) and
// becomes active only while the driver signals its latch gap (SWAP_REQ).
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   SSEL          raw active-low slave select (asynchronous)
//   RX_DATA       received byte, valid with RX_READY strobe
//   SWAP_REQ      per-channel driver latch-gap level
//   RD_CH/RD_ADDR read channel / pixel index
//   RD_DATA       active-bank pixel, 1-cycle latency (0 when RD_LIT=0)
//   RD_LIT        RD_ADDR below the active pixel count of RD_CH
//   PENDING       per-channel committed frame awaiting swap
//   ACTIVE_BANK   per-channel displayed bank
//   ERR_BADCH     sticky: header byte out of channel range
//   ERR_OVF       sticky: more than NUM_LEDS pixels in a frame
//   ERR_PARTIAL   sticky: frame ended mid-pixel
// -----------------------------------------------------------------------------
module spi_pixel_frame_store
   import spi_pix_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS  = 4,
   parameter int unsigned NUM_LEDS      = 8,
   parameter int unsigned BYTES_PER_LED = 3,
   parameter int unsigned LED_AW        = $clog2(NUM_LEDS),
   parameter int unsigned CH_AW         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                                  CLK,
   input  logic                                  RST,
   input  logic                                  SSEL,
   input  logic [7:0]                            RX_DATA,
   input  logic                                  RX_READY,
   input  logic [NUM_CHANNELS-1:0]               SWAP_REQ,
   input  logic [CH_AW-1:0]                      RD_CH,
   input  logic [LED_AW-1:0]                     RD_ADDR,
   output logic [pix_width(BYTES_PER_LED)-1:0]   RD_DATA,
   output logic                                  RD_LIT,
   output logic [NUM_CHANNELS-1:0]               PENDING,
   output logic [NUM_CHANNELS-1:0]               ACTIVE_BANK,
   output logic                                  ERR_BADCH,
   output logic                                  ERR_OVF,
   output logic                                  ERR_PARTIAL
);

   if (!bpl_legal(BYTES_PER_LED)) begin : g_bpl_check
      $error("BYTES_PER_LED must be 3 or 4");
   end

   localparam int unsigned PW = pix_width(BYTES_PER_LED);
   localparam int unsigned CW = LED_AW + 1;
   localparam int unsigned AW = CH_AW + 1 + LED_AW;
   localparam logic [CW-1:0] CNT_MAX  = CW'(NUM_LEDS);
   localparam logic [1:0]    IDX_LAST = 2'(BYTES_PER_LED - 1);

   // SSEL synchroniser and edge history
   logic r_ssel_meta;
   logic r_ssel_sync;
   logic r_ssel_hist;
   logic w_start;
   logic w_end;

   // receive FSM
   state_t            r_state;
   logic [CH_AW-1:0]  r_cur_ch;
   logic [1:0]        r_byte_idx;
   logic [CW-1:0]     r_addr;
   logic [PW-9:0]     r_acc;

   // per-channel bookkeeping
   logic [CW-1:0]           r_shadow_cnt [NUM_CHANNELS];
   logic [CW-1:0]           r_active_cnt [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] r_pending;
   logic [NUM_CHANNELS-1:0] r_active_bank;
   logic                    r_err_badch;
   logic                    r_err_ovf;
   logic                    r_err_partial;

   // datapath wires
   logic                    w_hdr_ok;
   logic [CH_AW-1:0]        w_hdr_ch;
   logic                    w_full;
   logic                    w_accept;
   logic                    w_last;
   logic                    w_wr_en;
   logic [PW-1:0]           w_wr_data;
   logic [AW-1:0]           w_wr_addr;
   logic [1:0]              w_idx_nx;
   logic [NUM_CHANNELS-1:0] w_swap;

   // read side
   logic             w_rd_ch_ok;
   logic [CH_AW-1:0] w_rd_ch;
   logic [AW-1:0]    w_rd_addr;
   logic             w_rd_lit;
   logic             r_rd_lit;
   logic [PW-1:0]    w_ram_q;

   assign w_start = r_ssel_hist & ~r_ssel_sync;
   assign w_end   = ~r_ssel_hist & r_ssel_sync;

   assign w_hdr_ok  = 32'(RX_DATA) < NUM_CHANNELS;
   assign w_hdr_ch  = RX_DATA[CH_AW-1:0];
   assign w_full    = (r_addr == CNT_MAX);
   assign w_accept  = (r_state == S_PIX) && RX_READY && !w_full;
   assign w_last    = (r_byte_idx == IDX_LAST);
   assign w_wr_en   = w_accept && w_last;
   assign w_wr_data = {r_acc, RX_DATA};
   assign w_wr_addr = {r_cur_ch, ~r_active_bank[r_cur_ch], r_addr[LED_AW-1:0]};

   // byte index after this cycle's byte; the end-of-frame partial check
   // must see it so a byte arriving together with SSEL release counts
   always_comb begin
      w_idx_nx = r_byte_idx;
      if (w_accept) begin
         w_idx_nx = w_last ? 2'd0 : r_byte_idx + 2'd1;
      end
   end

   // a channel being filled never swaps; its shadow bank is in flux
   always_comb begin
      w_swap = '0;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         w_swap[c] = SWAP_REQ[c] && r_pending[c] &&
                     !((r_state == S_PIX) && (r_cur_ch == CH_AW'(c)));
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_ssel_meta   <= 1'b1;
         r_ssel_sync   <= 1'b1;
         r_ssel_hist   <= 1'b1;
         r_state       <= S_IDLE;
         r_cur_ch      <= '0;
         r_byte_idx    <= '0;
         r_addr        <= '0;
         r_acc         <= '0;
         r_pending     <= '0;
         r_active_bank <= '0;
         r_err_badch   <= 1'b0;
         r_err_ovf     <= 1'b0;
         r_err_partial <= 1'b0;
         for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            r_shadow_cnt[c] <= '0;
            r_active_cnt[c] <= '0;
         end
      end else begin
         r_ssel_meta <= SSEL;
         r_ssel_sync <= r_ssel_meta;
         r_ssel_hist <= r_ssel_sync;

         // swaps first; header/commit assignments below take precedence
         for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            if (w_swap[c]) begin
               r_active_bank[c] <= ~r_active_bank[c];
               r_active_cnt[c]  <= r_shadow_cnt[c];
               r_pending[c]     <= 1'b0;
            end
         end

         if (w_start) begin
            // also restarts a frame on an SSEL glitch outside IDLE
            r_state    <= S_HDR;
            r_byte_idx <= '0;
            r_addr     <= '0;
         end else begin
            case (r_state)
               S_IDLE: ;
               S_HDR: begin
                  if (RX_READY && w_hdr_ok) begin
                     r_cur_ch               <= w_hdr_ch;
                     r_shadow_cnt[w_hdr_ch] <= '0;
                     // header then immediate release commits an empty frame
                     r_pending[w_hdr_ch]    <= w_end;
                     r_state                <= w_end ? S_IDLE : S_PIX;
                  end else if (RX_READY) begin
                     r_err_badch <= 1'b1;
                     r_state     <= w_end ? S_IDLE : S_DROP;
                  end else if (w_end) begin
                     r_state <= S_IDLE;
                  end
               end
               S_PIX: begin
                  if (RX_READY && w_full) begin
                     r_err_ovf <= 1'b1;
                  end
                  if (w_accept) begin
                     r_acc      <= {r_acc[PW-17:0], RX_DATA};
                     r_byte_idx <= w_idx_nx;
                  end
                  if (w_wr_en) begin
                     r_addr <= r_addr + CW'(1);
                     if (r_shadow_cnt[r_cur_ch] != CNT_MAX) begin
                        r_shadow_cnt[r_cur_ch] <= r_shadow_cnt[r_cur_ch] + CW'(1);
                     end
                  end
                  if (w_end) begin
                     r_state             <= S_IDLE;
                     r_pending[r_cur_ch] <= 1'b1;
                     if (w_idx_nx != 2'd0) begin
                        r_err_partial <= 1'b1;
                     end
                  end
               end
               S_DROP: begin
                  if (w_end) begin
                     r_state <= S_IDLE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // read side: bank selected in the same cycle as the address
   assign w_rd_ch_ok = 32'(RD_CH) < NUM_CHANNELS;
   assign w_rd_ch    = w_rd_ch_ok ? RD_CH : '0;
   assign w_rd_addr  = {w_rd_ch, r_active_bank[w_rd_ch], RD_ADDR};
   assign w_rd_lit   = w_rd_ch_ok && ({1'b0, RD_ADDR} < r_active_cnt[w_rd_ch]);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_rd_lit <= 1'b0;
      end else begin
         r_rd_lit <= w_rd_lit;
      end
   end

   pix_sdp_ram #(
      .AW (AW),
      .DW (PW)
   ) u_ram (
      .i_clk   (CLK),
      .i_we    (w_wr_en),
      .i_waddr (w_wr_addr),
      .i_wdata (w_wr_data),
      .i_raddr (w_rd_addr),
      .o_rdata (w_ram_q)
   );

   assign RD_DATA     = r_rd_lit ? w_ram_q : '0;
   assign RD_LIT      = r_rd_lit;
   assign PENDING     = r_pending;
   assign ACTIVE_BANK = r_active_bank;
   assign ERR_BADCH   = r_err_badch;
   assign ERR_OVF     = r_err_ovf;
   assign ERR_PARTIAL = r_err_partial;

endmodule

// File: tb/tb_spi_pixel_frame_store.sv
// -----------------------------------------------------------------------------
// tb_spi_pixel_frame_store
// Directed bench for spi_pixel_frame_store: a 4-channel GRB instance (A) and a
// 2-channel GRBW instance (B). Read-back expectations are held in a table of
// hand-computed vectors; multi-cycle corner cases are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_spi_pixel_frame_store;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   // instance A: 4 channels, 3 bytes per LED
   logic        rst_a, ssel_a, rdy_a;
   logic [7:0]  data_a;
   logic [3:0]  swap_a;
   logic [1:0]  rdch_a;
   logic [2:0]  rdaddr_a;
   logic [23:0] rddata_a;
   logic        rdlit_a;
   logic [3:0]  pend_a, bank_a;
   logic        ebad_a, eovf_a, epart_a;

   // instance B: 2 channels, 4 bytes per LED
   logic        rst_b, ssel_b, rdy_b;
   logic [7:0]  data_b;
   logic [1:0]  swap_b;
   logic [0:0]  rdch_b;
   logic [2:0]  rdaddr_b;
   logic [31:0] rddata_b;
   logic        rdlit_b;
   logic [1:0]  pend_b, bank_b;
   logic        ebad_b, eovf_b, epart_b;

   spi_pixel_frame_store #(
      .NUM_CHANNELS  (4),
      .NUM_LEDS      (8),
      .BYTES_PER_LED (3)
   ) dut_a (
      .CLK (CLK), .RST (rst_a), .SSEL (ssel_a),
      .RX_DATA (data_a), .RX_READY (rdy_a), .SWAP_REQ (swap_a),
      .RD_CH (rdch_a), .RD_ADDR (rdaddr_a),
      .RD_DATA (rddata_a), .RD_LIT (rdlit_a),
      .PENDING (pend_a), .ACTIVE_BANK (bank_a),
      .ERR_BADCH (ebad_a), .ERR_OVF (eovf_a), .ERR_PARTIAL (epart_a)
   );

   spi_pixel_frame_store #(
      .NUM_CHANNELS  (2),
      .NUM_LEDS      (8),
      .BYTES_PER_LED (4)
   ) dut_b (
      .CLK (CLK), .RST (rst_b), .SSEL (ssel_b),
      .RX_DATA (data_b), .RX_READY (rdy_b), .SWAP_REQ (swap_b),
      .RD_CH (rdch_b), .RD_ADDR (rdaddr_b),
      .RD_DATA (rddata_b), .RD_LIT (rdlit_b),
      .PENDING (pend_b), .ACTIVE_BANK (bank_b),
      .ERR_BADCH (ebad_b), .ERR_OVF (eovf_b), .ERR_PARTIAL (epart_b)
   );

   typedef struct {
      logic [1:0]  ch;
      logic [2:0]  addr;
      logic [23:0] data;
      logic        lit;
   } rd_vec_t;

   rd_vec_t tbl [12];
   int n_pass  = 0;
   int n_total = 0;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic spi_begin(input bit b);
      if (b) ssel_b = 1'b0; else ssel_a = 1'b0;
      repeat (4) tick();
   endtask

   task automatic spi_byte(input bit b, input logic [7:0] v);
      if (b) begin data_b = v; rdy_b = 1'b1; end
      else   begin data_a = v; rdy_a = 1'b1; end
      tick();
      rdy_a = 1'b0;
      rdy_b = 1'b0;
      tick();
   endtask

   task automatic spi_end(input bit b);
      if (b) ssel_b = 1'b1; else ssel_a = 1'b1;
      repeat (5) tick();
   endtask

   task automatic rd(input bit b, input logic [1:0] ch, input logic [2:0] addr,
                     output logic [31:0] d, output logic l);
      if (b) begin rdch_b = ch[0:0]; rdaddr_b = addr; end
      else   begin rdch_a = ch;      rdaddr_a = addr; end
      tick();
      d = b ? rddata_b : {8'h00, rddata_a};
      l = b ? rdlit_b  : rdlit_a;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic        l;
      int          pend_cyc;
      int          bank_cyc;

      tbl[0]  = '{2'd1, 3'd0, 24'h112233, 1'b1};
      tbl[1]  = '{2'd1, 3'd1, 24'h445566, 1'b1};
      tbl[2]  = '{2'd1, 3'd2, 24'h000000, 1'b0};
      tbl[3]  = '{2'd2, 3'd0, 24'hC1C2C3, 1'b1};
      tbl[4]  = '{2'd2, 3'd1, 24'hC4C5C6, 1'b1};
      tbl[5]  = '{2'd2, 3'd2, 24'h000000, 1'b0};
      tbl[6]  = '{2'd3, 3'd0, 24'h010203, 1'b1};
      tbl[7]  = '{2'd3, 3'd3, 24'h313233, 1'b1};
      tbl[8]  = '{2'd3, 3'd7, 24'h717273, 1'b1};
      tbl[9]  = '{2'd0, 3'd0, 24'hA1A2A3, 1'b1};
      tbl[10] = '{2'd0, 3'd1, 24'hA4A5A6, 1'b1};
      tbl[11] = '{2'd0, 3'd2, 24'h000000, 1'b0};

      rst_a = 1'b1; ssel_a = 1'b1; rdy_a = 1'b0; data_a = '0; swap_a = '0;
      rdch_a = '0; rdaddr_a = '0;
      rst_b = 1'b1; ssel_b = 1'b1; rdy_b = 1'b0; data_b = '0; swap_b = '0;
      rdch_b = '0; rdaddr_b = '0;
      repeat (3) tick();
      rst_a = 1'b0;
      rst_b = 1'b0;
      tick();

      // reset state
      chk("rst_a_rd",   {rddata_a, rdlit_a}, 0);
      chk("rst_a_stat", {pend_a, bank_a, ebad_a, eovf_a, epart_a}, 0);
      chk("rst_b_stat", {rddata_b, rdlit_b, pend_b, bank_b, ebad_b, eovf_b, epart_b}, 0);

      // seed channel 2 with one pixel and display it
      spi_begin(0);
      spi_byte(0, 8'h02);
      spi_byte(0, 8'hAA); spi_byte(0, 8'hBB); spi_byte(0, 8'hCC);
      spi_end(0);
      chk("seed_pend", pend_a, 4'b0100);
      swap_a = 4'b0100; tick(); swap_a = '0; tick();
      chk("seed_bank", {bank_a, pend_a}, {4'b0100, 4'b0000});

      // channel 2 refill with SWAP_REQ[2] held: no swap before release,
      // old frame readable meanwhile, swap one cycle after commit
      swap_a = 4'b0100;
      spi_begin(0);
      spi_byte(0, 8'h02);
      spi_byte(0, 8'hC1); spi_byte(0, 8'hC2); spi_byte(0, 8'hC3);
      rd(0, 2'd2, 3'd0, d, l);
      chk("old_ch2_data", d, 32'h00AABBCC);
      chk("old_ch2_lit", l, 1'b1);
      spi_byte(0, 8'hC4); spi_byte(0, 8'hC5); spi_byte(0, 8'hC6);
      chk("no_early_swap", {bank_a, pend_a}, {4'b0100, 4'b0000});
      ssel_a = 1'b1;
      pend_cyc = -1;
      bank_cyc = -1;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (pend_a[2] && pend_cyc < 0) pend_cyc = i;
         if (!bank_a[2] && bank_cyc < 0) bank_cyc = i;
      end
      swap_a = '0;
      chk("commit_seen", pend_cyc >= 0, 1'b1);
      chk("swap_latency", bank_cyc - pend_cyc, 1);
      chk("after_ch2_swap", {bank_a, pend_a}, {4'b0000, 4'b0000});

      // channel 1: two RGB pixels
      spi_begin(0);
      spi_byte(0, 8'h01);
      spi_byte(0, 8'h11); spi_byte(0, 8'h22); spi_byte(0, 8'h33);
      spi_byte(0, 8'h44); spi_byte(0, 8'h55); spi_byte(0, 8'h66);
      spi_end(0);
      chk("ch1_commit", {pend_a, ebad_a, eovf_a, epart_a}, {4'b0010, 3'b000});

      // bad channel header: bytes dropped, nothing committed
      spi_begin(0);
      spi_byte(0, 8'h07);
      spi_byte(0, 8'h11); spi_byte(0, 8'h22); spi_byte(0, 8'h33);
      spi_end(0);
      chk("badch", {pend_a, ebad_a, eovf_a, epart_a}, {4'b0010, 3'b100});

      // channel 3: 9 pixels into an 8-pixel string
      spi_begin(0);
      spi_byte(0, 8'h03);
      for (int k = 0; k < 9; k++) begin
         spi_byte(0, 8'(k * 16 + 1));
         spi_byte(0, 8'(k * 16 + 2));
         spi_byte(0, 8'(k * 16 + 3));
      end
      spi_end(0);
      chk("overflow", {pend_a, eovf_a, epart_a}, {4'b1010, 2'b10});

      // channel 0: 7 bytes = 2 pixels + 1 stray byte
      spi_begin(0);
      spi_byte(0, 8'h00);
      for (int k = 1; k <= 7; k++) spi_byte(0, 8'(8'hA0 + k));
      spi_end(0);
      chk("partial", {pend_a, epart_a}, {4'b1011, 1'b1});

      swap_a = 4'b1011; tick(); swap_a = '0; tick();
      chk("multi_swap", {bank_a, pend_a}, {4'b1011, 4'b0000});

      for (int i = 0; i < 12; i++) begin
         rd(0, tbl[i].ch, tbl[i].addr, d, l);
         chk($sformatf("rd_ch%0d_a%0d_data", tbl[i].ch, tbl[i].addr), d, {8'h00, tbl[i].data});
         chk($sformatf("rd_ch%0d_a%0d_lit", tbl[i].ch, tbl[i].addr), l, tbl[i].lit);
      end

      // instance B: GRBW pixel
      spi_begin(1);
      spi_byte(1, 8'h01);
      spi_byte(1, 8'hAA); spi_byte(1, 8'hBB); spi_byte(1, 8'hCC); spi_byte(1, 8'hDD);
      spi_end(1);
      chk("b_commit", pend_b, 2'b10);
      swap_b = 2'b10; tick(); swap_b = '0; tick();
      chk("b_bank", {bank_b, pend_b}, {2'b10, 2'b00});
      rd(1, 2'd1, 3'd0, d, l);
      chk("b_rgbw_data", d, 32'hAABBCCDD);
      chk("b_rgbw_lit", l, 1'b1);

      // instance B: reset mid-frame clears everything
      spi_begin(1);
      spi_byte(1, 8'h00);
      spi_byte(1, 8'h11); spi_byte(1, 8'h22);
      rst_b = 1'b1;
      ssel_b = 1'b1;
      tick();
      tick();
      chk("b_rst_stat", {pend_b, bank_b, ebad_b, eovf_b, epart_b}, 0);
      chk("b_rst_rd", {rddata_b, rdlit_b}, 0);
      rst_b = 1'b0;
      repeat (3) tick();

      spi_begin(1);
      spi_byte(1, 8'h00);
      spi_byte(1, 8'h55); spi_byte(1, 8'h66); spi_byte(1, 8'h77); spi_byte(1, 8'h88);
      spi_end(1);
      chk("b_post_rst", {pend_b, ebad_b, eovf_b, epart_b}, {2'b01, 3'b000});
      swap_b = 2'b01; tick(); swap_b = '0; tick();
      rd(1, 2'd0, 3'd0, d, l);
      chk("b_post_rst_data", d, 32'h55667788);
      chk("b_post_rst_lit", l, 1'b1);
      rd(1, 2'd1, 3'd0, d, l);
      chk("b_ch1_cleared_lit", {d, l}, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
